ft_read: RTL and testbench

FT_READ -- requirements
Module: ft_read

---
 rtl/ft_read_if.sv | 32 +++
 rtl/ft_read.sv | 133 +++++++++++++
 tb/tb_ft_read.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ft_read_if.sv
// ft_read_if: USB FIFO read pins plus the byte-stream valid/ready handshake.
// Revision: 1.0
`default_nettype none

interface ft_read_if;
  logic       io_RXF_N;
  logic [7:0] io_Data;
  logic       io_RD_N;
  logic       io_Handshaking_valid;
  logic       io_Handshaking_ready;
  logic [7:0] io_Handshaking_bits;

  modport master (
    input  io_RXF_N,
    input  io_Data,
    output io_RD_N,
    output io_Handshaking_valid,
    input  io_Handshaking_ready,
    output io_Handshaking_bits
  );

  modport slave (
    output io_RXF_N,
    output io_Data,
    input  io_RD_N,
    input  io_Handshaking_valid,
    output io_Handshaking_ready,
    input  io_Handshaking_bits
  );
endinterface

`default_nettype wire

// File: rtl/ft_read.sv
// ft_read: strobes bytes out of a USB FIFO chip into a first-word fall-through buffer.
// Revision: 1.0
`default_nettype none

module ft_read #(
  parameter int RD_PULSE = 3,
  parameter int RD_GAP   = 2,
  parameter int DEPTH    = 4
) (
  input  logic     clock,
  input  logic     reset,
  ft_read_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [3:0]  PULSE_LOAD = 4'(RD_PULSE - 1);
  localparam logic [3:0]  GAP_LOAD   = 4'(RD_GAP - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    timer_q, timer_d;
  logic          rd_n_q, rd_n_d;
  logic          rxf_meta_q, rxf_meta_d;
  logic          rxf_s_q, rxf_s_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rd_n_d     = rd_n_q;
    rxf_meta_d = bus.io_RXF_N;
    rxf_s_d    = rxf_meta_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    push       = 1'b0;
    pop        = (count_q != '0) && bus.io_Handshaking_ready;

    // A read is only launched with a free slot, so the captured byte always has a home.
    case (state_q)
      IDLE: begin
        rd_n_d = 1'b1;
        if (!rxf_s_q && (count_q < DEPTH_C)) begin
          state_d = STROBE;
          timer_d = PULSE_LOAD;
          rd_n_d  = 1'b0;
        end
      end
      STROBE: begin
        if (timer_q == '0) begin
          push    = 1'b1;
          rd_n_d  = 1'b1;
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rd_n_d  = 1'b1;
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.io_Data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rd_n_q     <= 1'b1;
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_n_q     <= rd_n_d;
      rxf_meta_q <= rxf_meta_d;
      rxf_s_q    <= rxf_s_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.io_RD_N              = rd_n_q;
  assign bus.io_Handshaking_valid = (count_q != '0);
  assign bus.io_Handshaking_bits  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_ft_read.sv
// tb_ft_read: FIFO-chip model feeding ft_read, with a scoreboard on the consumer side.
// Revision: 1.0
`default_nettype none

module tb_ft_read;
  localparam int RD_PULSE = 3;
  localparam int RD_GAP   = 2;
  localparam int DEPTH    = 4;

  logic clock;
  logic reset;
  ft_read_if bus ();

  ft_read #(.RD_PULSE(RD_PULSE), .RD_GAP(RD_GAP), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int         checks;
  int         failures;
  int         strobes;
  int         low_len;
  int         ncyc;
  logic       prev_rd_n;
  logic       glitch_low;
  logic [7:0] idle_data;
  logic [7:0] chip_q [$];
  logic [7:0] exp_q [$];
  int         fall_q [$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Chip model and scoreboard: edge tracking at negedge, pin update at +2, pop-sampling at +4.
  always @(negedge clock) begin
    logic [7:0] e;
    ncyc++;
    if (bus.io_RD_N == 1'b0) begin
      if (prev_rd_n) begin
        strobes++;
        fall_q.push_back(ncyc);
      end
      low_len++;
    end else if (!prev_rd_n) begin
      chk("pulse_len", low_len, RD_PULSE);
      if (reset && chip_q.size() > 0) void'(chip_q.pop_front());
      low_len = 0;
    end
    prev_rd_n = bus.io_RD_N;
    #2;
    bus.io_RXF_N = glitch_low ? 1'b0 : (chip_q.size() == 0);
    bus.io_Data  = (chip_q.size() != 0) ? chip_q[0] : idle_data;
    #2;
    if (bus.io_Handshaking_valid && bus.io_Handshaking_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte got=%0h want=none", bus.io_Handshaking_bits);
      end else begin
        e = exp_q.pop_front();
        if (bus.io_Handshaking_bits !== e) begin
          failures++;
          $display("FAIL data_order got=%0h want=%0h", bus.io_Handshaking_bits, e);
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && chip_q.size() == 0) break;
    end
    chk(name, (i < budget) ? 1 : 0, 1);
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_low_full(input string name);
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clock);
      #1;
      if (low_len == RD_PULSE) break;
    end
    chk(name, (i < 30) ? 1 : 0, 1);
  endtask

  initial begin
    logic [7:0] rdn_exp;
    logic [7:0] val_exp;
    int s0;
    int i;
    checks = 0; failures = 0; strobes = 0; low_len = 0; ncyc = 0;
    prev_rd_n = 1'b1; glitch_low = 1'b0; idle_data = 8'h00;
    reset = 1'b0;
    bus.io_RXF_N = 1'b1;
    bus.io_Data = 8'h00;
    bus.io_Handshaking_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_rd_n", bus.io_RD_N, 1);
    chk("reset_valid", bus.io_Handshaking_valid, 0);
    chk("reset_bits", bus.io_Handshaking_bits, 0);
    #1 reset = 1'b1;
    repeat (5) @(negedge clock);

    // Single byte with exact latency
    #1;
    bus.io_Handshaking_ready = 1'b1;
    chip_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    rdn_exp = 8'b1110_0011;
    val_exp = 8'b0010_0000;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      chk($sformatf("single_rd_n_%0d", j), bus.io_RD_N, rdn_exp[j]);
      chk($sformatf("single_valid_%0d", j), bus.io_Handshaking_valid, val_exp[j]);
    end
    s0 = strobes;
    repeat (10) @(negedge clock);
    chk("single_no_second_strobe", strobes - s0, 0);
    drain("single_drain", 10);

    // Burst of eight with ready held high
    #1;
    fall_q.delete();
    for (int b = 1; b <= 8; b++) begin
      chip_q.push_back(8'(b));
      exp_q.push_back(8'(b));
    end
    drain("burst_drain", 100);
    chk("burst_strobes", fall_q.size(), 8);
    for (int j = 1; j < fall_q.size(); j++) begin
      chk($sformatf("burst_period_%0d", j), fall_q[j] - fall_q[j-1], RD_PULSE + RD_GAP + 1);
    end

    // Backpressure, one pop, then push and pop on the same edge
    #1;
    bus.io_Handshaking_ready = 1'b0;
    s0 = strobes;
    for (int b = 0; b < 7; b++) begin
      chip_q.push_back(8'h10 + 8'(b));
      exp_q.push_back(8'h10 + 8'(b));
    end
    repeat (40) @(negedge clock);
    chk("bp_strobes_full", strobes - s0, DEPTH);
    chk("bp_rd_n_high", bus.io_RD_N, 1);
    chk("bp_valid", bus.io_Handshaking_valid, 1);
    chk("bp_head", bus.io_Handshaking_bits, 8'h10);
    #1 bus.io_Handshaking_ready = 1'b1;
    @(negedge clock);
    #1 bus.io_Handshaking_ready = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (strobes - s0 == DEPTH + 1) break;
      @(negedge clock);
    end
    chk("bp_one_more_strobe", strobes - s0, DEPTH + 1);
    wait_low_full("simul_wait_pulse");
    bus.io_Handshaking_ready = 1'b1;
    @(negedge clock);
    #1 bus.io_Handshaking_ready = 1'b0;
    repeat (30) @(negedge clock);
    chk("simul_strobes", strobes - s0, DEPTH + 2);
    chk("simul_rd_n_high", bus.io_RD_N, 1);
    chk("simul_chip_left", chip_q.size(), 1);
    #1 bus.io_Handshaking_ready = 1'b1;
    drain("bp_drain", 60);
    chk("bp_empty_valid", bus.io_Handshaking_valid, 0);

    // Reset in the last cycle of a strobe
    #1;
    bus.io_Handshaking_ready = 1'b0;
    chip_q.push_back(8'h5A);
    wait_low_full("rst_wait_pulse");
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rd_n", bus.io_RD_N, 1);
    chk("rst_valid", bus.io_Handshaking_valid, 0);
    chk("rst_chip_kept", chip_q.size(), 1);
    #1 reset = 1'b1;
    rdn_exp = 8'b0000_0011;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      chk($sformatf("rst_resume_%0d", j + 1), bus.io_RD_N, rdn_exp[j]);
    end
    #1;
    exp_q.push_back(8'h5A);
    bus.io_Handshaking_ready = 1'b1;
    drain("rst_drain", 30);

    // One-cycle RXF_N glitch with an empty chip
    #1;
    idle_data = 8'h3C;
    exp_q.push_back(8'h3C);
    s0 = strobes;
    glitch_low = 1'b1;
    @(negedge clock);
    #1 glitch_low = 1'b0;
    repeat (20) @(negedge clock);
    chk("glitch_strobes", strobes - s0, 1);
    chk("glitch_consumed", exp_q.size(), 0);
    chk("glitch_rd_n_high", bus.io_RD_N, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
